cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 alu_in  input  alu_data  ALU result; valid when alu_in.fu_alu_done=1.
REQ-004 mem_in  input  mem_data  memory result; valid when mem_in.fu_mem_done=1.
REQ-005 b_in  input  b_data  branch result; valid when b_in.fu_b_done=1.
REQ-006 alu_ready, mem_ready, b_ready  output  1 each  source may present a result this cycle.
REQ-007 flush  input  1  mispredict recovery; discards all buffered results.
REQ-008 cdb_out  output  cdb_data  registered broadcast: valid, src[1:0], pd[6:0], data[31:0], rob_tag[4:0], mispredict, mispredict_tag[4:0], jalr_bne_signal, pc[31:0].

Function
REQ-009 Each source SHALL own one holding slot (valid bit plus payload).
REQ-010 A slot SHALL capture its input when done=1, ready=1 and flush=0; done while ready=0 SHALL be ignored (source holds).
REQ-011 ready SHALL equal (!slot_valid) OR (slot granted this cycle), so one source streams one result per cycle.
REQ-012 Each cycle, at most one valid slot SHALL be granted by 3-way round-robin over order ALU(0), MEM(1), BR(2), starting from rr_ptr.
REQ-013 After a grant to source k, rr_ptr SHALL become (k+1) mod 3; with no grant, rr_ptr SHALL hold.
REQ-014 The granted slot's payload SHALL be registered into cdb_out with cdb_out.valid=1, and the slot SHALL clear in the same edge unless refilled by REQ-010.
REQ-015 No grant SHALL register cdb_out.valid=0; other cdb_out fields hold their previous value.
REQ-016 Latency: result with done at edge N SHALL appear on cdb_out after edge N+1 when uncontended; worst case N+3.
REQ-017 Non-branch grants SHALL drive mispredict=0, mispredict_tag=0, jalr_bne_signal=0, pc=0; src SHALL encode 0=ALU,1=MEM,2=BR.
REQ-018 Results with pd=0 SHALL still be granted and broadcast (ROB completion uses rob_tag).
REQ-019 flush=1 SHALL clear all slots and register cdb_out.valid=0 at that edge; inputs that cycle dropped; rr_ptr unchanged; ready outputs SHALL be 1 the following cycle.
REQ-020 flush SHALL take precedence over simultaneous capture and grant.
REQ-021 A branch result with mispredict=1 SHALL be broadcast unmodified; the arbiter SHALL NOT generate flush itself.
REQ-022 All three slots full SHALL drain in round-robin order over three consecutive cycles with no bubble.

Reset
REQ-023 reset SHALL clear all slot valid bits, set rr_ptr=0 (ALU), and zero every cdb_out field.
REQ-024 During reset all ready outputs SHALL be 0; after deassertion they SHALL read 1.
REQ-025 reset mid-stream SHALL discard buffered results with no broadcast in the reset cycle.

Structure
REQ-026 cdb_data struct and source encodings CDB_SRC_ALU/MEM/BR SHALL be added to types_pkg.
REQ-027 Grant logic SHALL be a sub-module rr_arbiter3 (3 requests, pointer in, one-hot grant out); slots and output register reside in cdb_arbiter.

Verification
REQ-028 After reset, ALU done pd=12 data=0x5 rob=3 -> next cycle cdb valid src=0 pd=12 data=0x5 rob_tag=3.
REQ-029 ALU, MEM, BR done same cycle (rob 1,2,4), rr_ptr=0 -> broadcasts ALU, MEM, BR on three consecutive cycles; ready for MEM/BR low while waiting.
REQ-030 ALU done every cycle for 8 cycles alone -> 8 back-to-back broadcasts, alu_ready constantly 1.
REQ-031 MEM and BR slots full, flush asserted -> cdb valid 0 next cycle, no later broadcast of either, all ready 1.
REQ-032 BR done mispredict=1 mispredict_tag=7 pc=0x40 -> cdb mispredict=1 tag=7 pc=0x40 src=2; following ALU broadcast shows mispredict=0.
REQ-033 Reset asserted with ALU slot full -> no broadcast; post-reset rr_ptr=0, cdb fields zero.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the result-broadcast path.
//   cdb_src_e : source encodings on the common data bus (ALU=0, MEM=1, BR=2)
//   alu_data  : ALU functional-unit result (fu_alu_done qualifies it)
//   mem_data  : memory functional-unit result (fu_mem_done qualifies it)
//   b_data    : branch-unit result, including mispredict recovery info
//   cdb_data  : one registered broadcast on the common data bus
package types_pkg;

  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_MEM = 2'd1,
    CDB_SRC_BR  = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic        fu_alu_done;
    logic [6:0]  pd;
    logic [31:0] data;
    logic [4:0]  rob_tag;
  } alu_data;

  typedef struct packed {
    logic        fu_mem_done;
    logic [6:0]  pd;
    logic [31:0] data;
    logic [4:0]  rob_tag;
  } mem_data;

  typedef struct packed {
    logic        fu_b_done;
    logic [6:0]  pd;
    logic [31:0] data;
    logic [4:0]  rob_tag;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        jalr_bne_signal;
    logic [31:0] pc;
  } b_data;

  typedef struct packed {
    logic        valid;
    logic [1:0]  src;
    logic [6:0]  pd;
    logic [31:0] data;
    logic [4:0]  rob_tag;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        jalr_bne_signal;
    logic [31:0] pc;
  } cdb_data;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant.
//   req   : request per source (bit 0 = ALU, 1 = MEM, 2 = BR)
//   ptr   : source with highest priority this cycle; 3 is treated as 0
//   grant : one-hot grant, all zero when nothing requests
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant
);

  always_comb begin
    grant = 3'b000;
    case (ptr)
      2'd1: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit, a
// round-robin grant each cycle, and a registered broadcast.
//   clk, reset          : clock, synchronous active-high reset
//   alu_in/mem_in/b_in  : functional-unit results, qualified by their done bit
//   alu_/mem_/b_ready   : the unit may present a result this cycle
//   flush               : mispredict recovery, discards all buffered results
//   cdb_out             : registered broadcast (valid qualifies the payload)
//   rr_ptr_dbg          : current round-robin pointer (observation only)
//
// Handshake: a result transfers into its slot on a rising edge where
// done=1 and ready=1 (and no flush/reset). done with ready=0 is ignored and
// the unit must hold the result. ready = !slot_valid || slot granted now, so
// an uncontended unit can stream one result per cycle.
module cdb_arbiter
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  alu_data    alu_in,
  input  mem_data    mem_in,
  input  b_data      b_in,
  input  logic       flush,
  output logic       alu_ready,
  output logic       mem_ready,
  output logic       b_ready,
  output cdb_data    cdb_out,
  output logic [1:0] rr_ptr_dbg
);

  // The stored done bit doubles as the slot's valid bit.
  alu_data  alu_slot;
  mem_data  mem_slot;
  b_data    b_slot;
  cdb_src_e rr_ptr;
  cdb_src_e next_ptr;
  cdb_data  next_cdb;
  logic [2:0] grant;

  rr_arbiter3 u_rr (
    .req   ({b_slot.fu_b_done, mem_slot.fu_mem_done, alu_slot.fu_alu_done}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign alu_ready  = !reset && (!alu_slot.fu_alu_done || grant[0]);
  assign mem_ready  = !reset && (!mem_slot.fu_mem_done || grant[1]);
  assign b_ready    = !reset && (!b_slot.fu_b_done     || grant[2]);
  assign rr_ptr_dbg = rr_ptr;

  // With no grant the payload fields hold and only valid drops.
  // Non-branch grants zero the branch-only fields.
  always_comb begin
    next_cdb       = cdb_out;
    next_cdb.valid = 1'b0;
    next_ptr       = rr_ptr;
    if (grant[0]) begin
      next_cdb         = '0;
      next_cdb.valid   = 1'b1;
      next_cdb.src     = CDB_SRC_ALU;
      next_cdb.pd      = alu_slot.pd;
      next_cdb.data    = alu_slot.data;
      next_cdb.rob_tag = alu_slot.rob_tag;
      next_ptr         = CDB_SRC_MEM;
    end else if (grant[1]) begin
      next_cdb         = '0;
      next_cdb.valid   = 1'b1;
      next_cdb.src     = CDB_SRC_MEM;
      next_cdb.pd      = mem_slot.pd;
      next_cdb.data    = mem_slot.data;
      next_cdb.rob_tag = mem_slot.rob_tag;
      next_ptr         = CDB_SRC_BR;
    end else if (grant[2]) begin
      next_cdb.valid           = 1'b1;
      next_cdb.src             = CDB_SRC_BR;
      next_cdb.pd              = b_slot.pd;
      next_cdb.data            = b_slot.data;
      next_cdb.rob_tag         = b_slot.rob_tag;
      next_cdb.mispredict      = b_slot.mispredict;
      next_cdb.mispredict_tag  = b_slot.mispredict_tag;
      next_cdb.jalr_bne_signal = b_slot.jalr_bne_signal;
      next_cdb.pc              = b_slot.pc;
      next_ptr                 = CDB_SRC_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_slot <= '0;
      mem_slot <= '0;
      b_slot   <= '0;
      rr_ptr   <= CDB_SRC_ALU;
      cdb_out  <= '0;
    end else if (flush) begin
      // Flush beats capture and grant; the pointer is left where it was.
      alu_slot.fu_alu_done <= 1'b0;
      mem_slot.fu_mem_done <= 1'b0;
      b_slot.fu_b_done     <= 1'b0;
      cdb_out.valid        <= 1'b0;
    end else begin
      cdb_out <= next_cdb;
      rr_ptr  <= next_ptr;
      // Clear on grant first; a same-edge capture overrides the clear.
      if (grant[0]) alu_slot.fu_alu_done <= 1'b0;
      if (grant[1]) mem_slot.fu_mem_done <= 1'b0;
      if (grant[2]) b_slot.fu_b_done     <= 1'b0;
      if (alu_in.fu_alu_done && alu_ready) alu_slot <= alu_in;
      if (mem_in.fu_mem_done && mem_ready) mem_slot <= mem_in;
      if (b_in.fu_b_done     && b_ready)   b_slot   <= b_in;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import types_pkg::*;

  localparam int W = 85;  // cdb payload without the valid bit

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic flush;
  alu_data alu_in;
  mem_data mem_in;
  b_data   b_in;
  logic alu_ready, mem_ready, b_ready;
  cdb_data cdb_out;
  logic [1:0] rr_ptr_dbg;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .alu_in     (alu_in),
    .mem_in     (mem_in),
    .b_in       (b_in),
    .flush      (flush),
    .alu_ready  (alu_ready),
    .mem_ready  (mem_ready),
    .b_ready    (b_ready),
    .cdb_out    (cdb_out),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [1:0] src, input logic [6:0] pd,
                                        input logic [31:0] data, input logic [4:0] rob,
                                        input logic mp, input logic [4:0] mp_tag,
                                        input logic jb, input logic [31:0] pc);
    return {src, pd, data, rob, mp, mp_tag, jb, pc};
  endfunction

  function automatic logic [W-1:0] pack_out(input cdb_data c);
    return {c.src, c.pd, c.data, c.rob_tag, c.mispredict, c.mispredict_tag,
            c.jalr_bne_signal, c.pc};
  endfunction

  // Monitor: every broadcast must match the next expected entry.
  always @(negedge clk) begin
    if (cdb_out.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_broadcast: got %0h expected none", pack_out(cdb_out));
      end else begin
        check("cdb_payload", 128'(pack_out(cdb_out)), 128'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alu_in = '0;
    mem_in = '0;
    b_in   = '0;
    flush  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [6:0] pd, input logic [31:0] data, input logic [4:0] rob);
    alu_in.fu_alu_done = 1'b1;
    alu_in.pd = pd;
    alu_in.data = data;
    alu_in.rob_tag = rob;
  endtask

  task automatic set_mem(input logic [6:0] pd, input logic [31:0] data, input logic [4:0] rob);
    mem_in.fu_mem_done = 1'b1;
    mem_in.pd = pd;
    mem_in.data = data;
    mem_in.rob_tag = rob;
  endtask

  task automatic set_br(input logic [6:0] pd, input logic [31:0] data, input logic [4:0] rob,
                        input logic mp, input logic [4:0] mp_tag, input logic jb,
                        input logic [31:0] pc);
    b_in.fu_b_done = 1'b1;
    b_in.pd = pd;
    b_in.data = data;
    b_in.rob_tag = rob;
    b_in.mispredict = mp;
    b_in.mispredict_tag = mp_tag;
    b_in.jalr_bne_signal = jb;
    b_in.pc = pc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    check("reset_cdb_zero", 128'(cdb_out), 128'(0));
    check("reset_ready_low", 128'({alu_ready, mem_ready, b_ready}), 128'(3'b000));
    step();
    reset = 1'b0;
    #1;
    check("post_reset_ready", 128'({alu_ready, mem_ready, b_ready}), 128'(3'b111));
    check("post_reset_rr_ptr", 128'(rr_ptr_dbg), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Single uncontended ALU result: on the bus one edge after capture.
    set_alu(7'd12, 32'h5, 5'd3);
    exp_q.push_back(pack(2'd0, 7'd12, 32'h5, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0));
    step();
    idle_inputs();
    check("lat_not_yet", 128'(cdb_out.valid), 128'(0));
    step();
    check("lat_n_plus_1", 128'(cdb_out.valid), 128'(1));
    step();

    // All three at once from rr_ptr=0: ALU, MEM, BR back to back.
    do_reset();
    set_alu(7'd1, 32'h11, 5'd1);
    set_mem(7'd2, 32'h22, 5'd2);
    set_br(7'd4, 32'h44, 5'd4, 1'b0, 5'd0, 1'b0, 32'h80);
    exp_q.push_back(pack(2'd0, 7'd1, 32'h11, 5'd1, 1'b0, 5'd0, 1'b0, 32'h0));
    exp_q.push_back(pack(2'd1, 7'd2, 32'h22, 5'd2, 1'b0, 5'd0, 1'b0, 32'h0));
    exp_q.push_back(pack(2'd2, 7'd4, 32'h44, 5'd4, 1'b0, 5'd0, 1'b0, 32'h80));
    step();
    idle_inputs();
    check("full_ready_c0", 128'({alu_ready, mem_ready, b_ready}), 128'(3'b100));
    step();
    check("drain_valid_c1", 128'(cdb_out.valid), 128'(1));
    check("full_ready_c1", 128'({mem_ready, b_ready}), 128'(2'b10));
    step();
    check("drain_valid_c2", 128'(cdb_out.valid), 128'(1));
    check("full_ready_c2", 128'(b_ready), 128'(1));
    step();
    check("drain_valid_c3", 128'(cdb_out.valid), 128'(1));
    step();
    check("drain_done", 128'(cdb_out.valid), 128'(0));
    check("drain_rr_ptr", 128'(rr_ptr_dbg), 128'(0));

    // ALU streams 8 results back to back.
    for (int i = 0; i < 8; i++) begin
      set_alu(7'(20 + i), 32'h100 + 32'(i), 5'(i));
      exp_q.push_back(pack(2'd0, 7'(20 + i), 32'h100 + 32'(i), 5'(i), 1'b0, 5'd0, 1'b0, 32'h0));
      check("stream_alu_ready", 128'(alu_ready), 128'(1));
      if (i >= 2) check("stream_valid", 128'(cdb_out.valid), 128'(1));
      step();
    end
    idle_inputs();
    step();
    step();
    check("stream_rr_ptr", 128'(rr_ptr_dbg), 128'(1));

    // rr_ptr=1: MEM wins over ALU.
    set_alu(7'd30, 32'hA0, 5'd11);
    set_mem(7'd31, 32'hB0, 5'd12);
    exp_q.push_back(pack(2'd1, 7'd31, 32'hB0, 5'd12, 1'b0, 5'd0, 1'b0, 32'h0));
    exp_q.push_back(pack(2'd0, 7'd30, 32'hA0, 5'd11, 1'b0, 5'd0, 1'b0, 32'h0));
    step();
    idle_inputs();
    check("ptr1_ready", 128'({alu_ready, mem_ready}), 128'(2'b01));
    step();
    step();
    step();

    // Mispredicting branch broadcast unmodified, then ALU with pd=0.
    set_br(7'd5, 32'h99, 5'd9, 1'b1, 5'd7, 1'b1, 32'h40);
    exp_q.push_back(pack(2'd2, 7'd5, 32'h99, 5'd9, 1'b1, 5'd7, 1'b1, 32'h40));
    step();
    idle_inputs();
    set_alu(7'd0, 32'h1234, 5'd10);
    exp_q.push_back(pack(2'd0, 7'd0, 32'h1234, 5'd10, 1'b0, 5'd0, 1'b0, 32'h0));
    step();
    idle_inputs();
    check("br_mispredict", 128'({cdb_out.mispredict, cdb_out.mispredict_tag, cdb_out.pc}),
          128'({1'b1, 5'd7, 32'h40}));
    step();
    check("alu_after_br", 128'({cdb_out.valid, cdb_out.mispredict}), 128'(2'b10));
    step();

    // Flush with MEM and BR buffered plus a new ALU result: all dropped.
    set_mem(7'd40, 32'hC0, 5'd13);
    set_br(7'd41, 32'hD0, 5'd14, 1'b0, 5'd0, 1'b0, 32'h44);
    step();
    idle_inputs();
    flush = 1'b1;
    set_alu(7'd42, 32'hE0, 5'd15);
    step();
    idle_inputs();
    check("flush_cdb_invalid", 128'(cdb_out.valid), 128'(0));
    check("flush_ready", 128'({alu_ready, mem_ready, b_ready}), 128'(3'b111));
    check("flush_rr_ptr", 128'(rr_ptr_dbg), 128'(1));
    repeat (4) step();

    // Reset with the ALU slot full: nothing broadcast, everything zeroed.
    set_alu(7'd50, 32'hABC, 5'd16);
    step();
    idle_inputs();
    do_reset();
    repeat (3) step();

    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
